// File: rtl/ll_physics.sv
// Lunar-lander physics step: one tick runs a 5-cycle sequence that updates altitude,
// velocity and fuel (4-digit BCD, 10's complement) through one shared BCD adder.

module bcdaddsub4 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] s
);
    logic [3:0] bd;
    logic [4:0] raw;
    logic       cy;

    // Subtraction is a + 9's complement of b + 1, so the carry-in doubles as the +1.
    always_comb begin
        s   = '0;
        cy  = sub;
        bd  = '0;
        raw = '0;
        for (int i = 0; i < 4; i++) begin
            bd  = sub ? (4'd9 - b[4*i +: 4]) : b[4*i +: 4];
            raw = {1'b0, a[4*i +: 4]} + {1'b0, bd} + {4'd0, cy};
            if (raw > 5'd9) begin
                s[4*i +: 4] = raw[3:0] + 4'd6;
                cy          = 1'b1;
            end else begin
                s[4*i +: 4] = raw[3:0];
                cy          = 1'b0;
            end
        end
    end
endmodule

module ll_physics #(
    parameter logic [15:0] ALT_INIT  = 16'h4500,
    parameter logic [15:0] VEL_INIT  = 16'h0000,
    parameter logic [15:0] FUEL_INIT = 16'h0800,
    parameter logic [15:0] GRAVITY   = 16'h0005
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        wen,
    input  logic [3:0]  thrust,
    output logic [15:0] alt,
    output logic [15:0] vel,
    output logic [15:0] fuel,
    output logic        busy,
    output logic        done,
    output logic        overrun
);
    typedef enum logic [2:0] {IDLE, ALT, VEL1, VEL2, FUEL, COMMIT} state_t;

    state_t      state, state_nx;
    logic [3:0]  thr_q;
    logic [15:0] wa, wv, wf;
    logic [15:0] an_q, vn_q, fn_q;
    logic [15:0] t_eff;
    logic [15:0] op_a, op_b, sum;
    logic        op_sub;

    assign busy = (state != IDLE);

    // Thrust is capped by remaining fuel, so fuel can never go negative.
    assign t_eff = (wf < {12'd0, thr_q}) ? wf : {12'd0, thr_q};

    always_comb begin
        op_a   = '0;
        op_b   = '0;
        op_sub = 1'b0;
        case (state)
            ALT:     begin op_a = wa;   op_b = wv;      end
            VEL1:    begin op_a = wv;   op_b = t_eff;   end
            VEL2:    begin op_a = vn_q; op_b = GRAVITY; op_sub = 1'b1; end
            FUEL:    begin op_a = wf;   op_b = t_eff;   op_sub = 1'b1; end
            default: ;
        endcase
    end

    bcdaddsub4 u_add (.a(op_a), .b(op_b), .sub(op_sub), .s(sum));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (tick) state_nx = ALT;
            ALT:     state_nx = VEL1;
            VEL1:    state_nx = VEL2;
            VEL2:    state_nx = FUEL;
            FUEL:    state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            thr_q   <= '0;
            wa      <= '0;
            wv      <= '0;
            wf      <= '0;
            an_q    <= '0;
            vn_q    <= '0;
            fn_q    <= '0;
            alt     <= ALT_INIT;
            vel     <= VEL_INIT;
            fuel    <= FUEL_INIT;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done <= (state == COMMIT);
            if (tick && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (tick) begin
                    thr_q <= thrust;
                    wa    <= alt;
                    wv    <= vel;
                    wf    <= fuel;
                end
                ALT:  an_q <= (sum[15:12] >= 4'd5) ? 16'h0000 : sum;
                VEL1: vn_q <= sum;
                VEL2: vn_q <= sum;
                FUEL: fn_q <= sum;
                COMMIT: if (wen) begin
                    alt  <= an_q;
                    vel  <= vn_q;
                    fuel <= fn_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ll_physics.sv
// Directed bench for ll_physics: stimulus pushes expected results, a monitor checks on done.

module tb_ll_physics;
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] v;
        logic [15:0] f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wen = 1'b1;
    logic [3:0]  thrust = 4'd0;
    logic [2:0]  tick = '0;
    logic [2:0]  busy, done, ovr;
    logic [15:0] alt [3];
    logic [15:0] vel [3];
    logic [15:0] fuel [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ll_physics u0 (
        .clk(clk), .rst(rst), .tick(tick[0]), .wen(wen), .thrust(thrust),
        .alt(alt[0]), .vel(vel[0]), .fuel(fuel[0]),
        .busy(busy[0]), .done(done[0]), .overrun(ovr[0])
    );
    ll_physics #(.FUEL_INIT(16'h0003)) u1 (
        .clk(clk), .rst(rst), .tick(tick[1]), .wen(wen), .thrust(thrust),
        .alt(alt[1]), .vel(vel[1]), .fuel(fuel[1]),
        .busy(busy[1]), .done(done[1]), .overrun(ovr[1])
    );
    ll_physics #(.ALT_INIT(16'h0003), .VEL_INIT(16'h9990)) u2 (
        .clk(clk), .rst(rst), .tick(tick[2]), .wen(wen), .thrust(thrust),
        .alt(alt[2]), .vel(vel[2]), .fuel(fuel[2]),
        .busy(busy[2]), .done(done[2]), .overrun(ovr[2])
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic qpush(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (done[d] === 1'b1) begin
                if (qsize(d) == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done dut%0d: got done=1 expected none", d);
                end else begin
                    exp_t e;
                    e = qpop(d);
                    chk($sformatf("alt dut%0d", d),  alt[d],  e.a);
                    chk($sformatf("vel dut%0d", d),  vel[d],  e.v);
                    chk($sformatf("fuel dut%0d", d), fuel[d], e.f);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge where done should be high.
    // With extra set, a second tick lands on edge k+2 and thrust changes mid-update.
    task automatic do_tick(input int d, input logic [3:0] thr, input logic w,
                           input logic [15:0] ea, input logic [15:0] ev,
                           input logic [15:0] ef, input bit extra);
        exp_t e;
        e = '{a: ea, v: ev, f: ef};
        qpush(d, e);
        tick[d] = 1'b1;
        thrust  = thr;
        wen     = w;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tick[d] = extra && (i == 1);
            if (extra && i == 1) thrust = 4'd9;
            chk("busy_during", 16'(busy[d]), 16'd1);
            if (i == 0) chk("done_clear", 16'(done[d]), 16'd0);
        end
        @(negedge clk);
        tick[d] = 1'b0;
        thrust  = 4'd0;
        chk("busy_after", 16'(busy[d]), 16'd0);
        chk("done_pulse", 16'(done[d]), 16'd1);
    endtask

    initial begin
        #1 rst = 1'b0;
        #2;
        chk("rst_alt",  alt[0],  16'h4500);
        chk("rst_vel",  vel[0],  16'h0000);
        chk("rst_fuel", fuel[0], 16'h0800);
        chk("rst_busy", 16'(busy[0]), 16'd0);
        chk("rst_done", 16'(done[0]), 16'd0);
        chk("rst_ovr",  16'(ovr[0]),  16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Freefall twice, second tick in the done cycle.
        do_tick(0, 4'd0, 1'b1, 16'h4500, 16'h9995, 16'h0800, 1'b0);
        do_tick(0, 4'd0, 1'b1, 16'h4495, 16'h9990, 16'h0800, 1'b0);
        @(negedge clk);
        // Freeze: nothing commits but done still pulses.
        do_tick(0, 4'd0, 1'b0, 16'h4495, 16'h9990, 16'h0800, 1'b0);
        chk("ovr_clear", 16'(ovr[0]), 16'd0);
        @(negedge clk);
        // Overrun: stray tick ignored, mid-update thrust change ignored.
        do_tick(0, 4'd0, 1'b1, 16'h4485, 16'h9985, 16'h0800, 1'b1);
        chk("ovr_set", 16'(ovr[0]), 16'd1);
        @(negedge clk);
        chk("no_restart", 16'(busy[0]), 16'd0);
        chk("ovr_sticky", 16'(ovr[0]), 16'd1);

        // Fuel limit.
        do_tick(1, 4'd9, 1'b1, 16'h4500, 16'h9998, 16'h0000, 1'b0);
        @(negedge clk);
        do_tick(1, 4'd9, 1'b1, 16'h4498, 16'h9993, 16'h0000, 1'b0);
        chk("ovr_u1", 16'(ovr[1]), 16'd0);
        @(negedge clk);

        // Ground clamp.
        do_tick(2, 4'd0, 1'b1, 16'h0000, 16'h9985, 16'h0800, 1'b0);
        @(negedge clk);

        // Abort: reset before edge k+3.
        tick[0] = 1'b1;
        wen     = 1'b1;
        @(negedge clk);
        tick[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_alt",  alt[0],  16'h4500);
        chk("abort_vel",  vel[0],  16'h0000);
        chk("abort_fuel", fuel[0], 16'h0800);
        chk("abort_busy", 16'(busy[0]), 16'd0);
        chk("abort_ovr",  16'(ovr[0]),  16'd0);
        repeat (3) @(negedge clk);
        chk("abort_nodone", 16'(done[0]), 16'd0);
        rst = 1'b1;
        // First tick straight after reset release.
        do_tick(0, 4'd0, 1'b1, 16'h4500, 16'h9995, 16'h0800, 1'b0);

        repeat (4) @(negedge clk);
        chk("q0_drained", 16'(qsize(0)), 16'd0);
        chk("q1_drained", 16'(qsize(1)), 16'd0);
        chk("q2_drained", 16'(qsize(2)), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
